uart_apb_host: RTL and testbench



---
 rtl/uart_apb_host_pkg.sv | 42 ++++
 rtl/uart_apb_host_xfer.sv | 76 +++++++
 rtl/uart_apb_host.sv | 209 ++++++++++++++++++++
 tb/tb_uart_apb_host.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_host_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_apb_host_pkg
// Brief   : UART register map, CTRL/STATUS bit positions, CTRL command values
//           and sequencer state encoding shared by the uart_apb_host files.
// Rev     : 1.0
// ============================================================================
package uart_apb_host_pkg;

    localparam logic [31:0] C_REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] C_REG_STATUS  = 32'h0000_0004;
    localparam logic [31:0] C_REG_TX_DATA = 32'h0000_0008;
    localparam logic [31:0] C_REG_RX_DATA = 32'h0000_000C;

    localparam int C_CTRL_TX_EN  = 0;
    localparam int C_CTRL_TX_RST = 1;
    localparam int C_CTRL_RX_EN  = 2;
    localparam int C_CTRL_RX_RST = 3;

    localparam int C_ST_TX_BUSY  = 0;
    localparam int C_ST_TX_DONE  = 1;
    localparam int C_ST_RX_BUSY  = 2;
    localparam int C_ST_RX_DONE  = 3;
    localparam int C_ST_RX_ERR   = 4;

    localparam logic [31:0] C_CTRL_INIT_RST = 32'h0000_000A;
    localparam logic [31:0] C_CTRL_RUN      = 32'h0000_0005;
    localparam logic [31:0] C_CTRL_ERR_RST  = 32'h0000_0009;

    typedef enum logic [2:0] {
        S_INIT_RST = 3'd0,
        S_INIT_EN  = 3'd1,
        S_GAP      = 3'd2,
        S_POLL     = 3'd3,
        S_RD_RX    = 3'd4,
        S_WR_TX    = 3'd5,
        S_ERR_RST  = 3'd6,
        S_ERR_EN   = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_apb_host_xfer.sv
`default_nettype none
// ============================================================================
// Module : uart_apb_host_xfer
// Brief  : Single APB master transfer engine: SETUP, ACCESS until PREADY,
//          abort after TIMEOUT ACCESS cycles. done_o/timeout_o mark the edge.
// Rev    : 1.0
// ============================================================================
module uart_apb_host_xfer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;
    logic [TW-1:0] tcnt_q;

    assign done_o    = psel_q && penable_q && pready_i;
    assign timeout_o = psel_q && penable_q && !pready_i && (tcnt_q == TW'(TIMEOUT - 1));
    assign rdata_o   = prdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            tcnt_q    <= '0;
        end else if (!psel_q) begin
            // Address/data are latched here so they stay fixed for the transfer.
            if (start_i) begin
                psel_q   <= 1'b1;
                pwrite_q <= write_i;
                paddr_q  <= addr_i;
                pwdata_q <= wdata_i;
                tcnt_q   <= '0;
            end
        end else if (!penable_q) begin
            penable_q <= 1'b1;
        end else if (done_o || timeout_o) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;

endmodule
`default_nettype wire

// File: rtl/uart_apb_host.sv
`default_nettype none
// ============================================================================
// Module : uart_apb_host
// Brief  : APB sequencer that brings up the UART, polls STATUS and moves TX/RX
//          bytes. Define UART_APB_HOST_ERRCNT_EN to add the err_count output.
// Rev    : 1.0
// ============================================================================
module uart_apb_host
    import uart_apb_host_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          POLL_GAP  = 4,
    parameter int          TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_err,
    output logic        bus_err,
    output logic        init_done
`ifdef UART_APB_HOST_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    // With no gap the sequencer returns straight to POLL after every transfer.
    localparam state_e S_AFTER_XFER = (POLL_GAP == 0) ? S_POLL : S_GAP;

    state_e      state_q, state_d;
    logic        issued_q, issued_d;
    logic [15:0] gap_q, gap_d;
    logic        init_done_q, init_done_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_ready_q, tx_ready_d;
    logic        rx_err_q, rx_err_d;
    logic        bus_err_q, bus_err_d;

    logic        w_start;
    logic [31:0] w_addr;
    logic        w_write;
    logic [31:0] w_wdata;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_rdata;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^w_rdata[31:8];

    uart_apb_host_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .start_i   (w_start),
        .addr_i    (w_addr),
        .write_i   (w_write),
        .wdata_i   (w_wdata),
        .pready_i  (PREADY),
        .prdata_i  (PRDATA),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .paddr_o   (PADDR),
        .pwdata_o  (PWDATA),
        .done_o    (w_done),
        .rdata_o   (w_rdata),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        gap_d       = gap_q;
        init_done_d = init_done_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        tx_ready_d  = 1'b0;
        rx_err_d    = 1'b0;
        bus_err_d   = 1'b0;
        w_start     = 1'b0;
        w_addr      = ADDR_BASE + C_REG_STATUS;
        w_write     = 1'b0;
        w_wdata     = 32'h0;

        case (state_q)
            S_INIT_RST: begin w_addr = ADDR_BASE + C_REG_CTRL;    w_write = 1'b1; w_wdata = C_CTRL_INIT_RST; end
            S_INIT_EN:  begin w_addr = ADDR_BASE + C_REG_CTRL;    w_write = 1'b1; w_wdata = C_CTRL_RUN;      end
            S_RD_RX:    begin w_addr = ADDR_BASE + C_REG_RX_DATA; end
            S_WR_TX:    begin w_addr = ADDR_BASE + C_REG_TX_DATA; w_write = 1'b1; w_wdata = {24'b0, tx_byte}; end
            S_ERR_RST:  begin w_addr = ADDR_BASE + C_REG_CTRL;    w_write = 1'b1; w_wdata = C_CTRL_ERR_RST;  end
            S_ERR_EN:   begin w_addr = ADDR_BASE + C_REG_CTRL;    w_write = 1'b1; w_wdata = C_CTRL_RUN;      end
            default:    ;
        endcase

        if (state_q == S_GAP) begin
            if (gap_q == 16'(POLL_GAP - 1)) begin
                gap_d   = 16'd0;
                state_d = S_POLL;
            end else begin
                gap_d = gap_q + 16'd1;
            end
        end else if (!issued_q) begin
            // The first cycle of each transfer state is the mandatory idle bus cycle.
            if (state_q == S_WR_TX && !tx_valid) begin
                state_d = S_AFTER_XFER;
            end else begin
                w_start  = 1'b1;
                issued_d = 1'b1;
            end
        end else if (w_timeout) begin
            issued_d  = 1'b0;
            bus_err_d = 1'b1;
            state_d   = (state_q == S_INIT_RST || state_q == S_INIT_EN) ? S_INIT_RST : S_AFTER_XFER;
        end else if (w_done) begin
            issued_d = 1'b0;
            case (state_q)
                S_INIT_RST: state_d = S_INIT_EN;
                S_INIT_EN: begin
                    init_done_d = 1'b1;
                    state_d     = S_AFTER_XFER;
                end
                S_POLL: begin
                    if (w_rdata[C_ST_RX_ERR]) begin
                        rx_err_d = 1'b1;
                        state_d  = S_ERR_RST;
                    end else if (w_rdata[C_ST_RX_DONE]) begin
                        state_d = S_RD_RX;
                    end else if (tx_valid && !w_rdata[C_ST_TX_BUSY]) begin
                        state_d = S_WR_TX;
                    end else begin
                        state_d = S_AFTER_XFER;
                    end
                end
                S_RD_RX: begin
                    rx_byte_d  = w_rdata[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = S_AFTER_XFER;
                end
                S_WR_TX: begin
                    tx_ready_d = 1'b1;
                    state_d    = S_AFTER_XFER;
                end
                S_ERR_RST: state_d = S_ERR_EN;
                S_ERR_EN:  state_d = S_AFTER_XFER;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_INIT_RST;
            issued_q    <= 1'b0;
            gap_q       <= 16'd0;
            init_done_q <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            rx_err_q    <= rx_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_byte   = rx_byte_q;
    assign rx_err    = rx_err_q;
    assign bus_err   = bus_err_q;
    assign init_done = init_done_q;

`ifdef UART_APB_HOST_ERRCNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_count_q <= 8'h00;
        end else if ((rx_err_q || bus_err_q) && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_host.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_apb_host
// Brief  : Scoreboarded bench for uart_apb_host with a small UART slave model.
// Rev    : 1.0
// ============================================================================
module tb_uart_apb_host;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready, rx_valid, rx_err, bus_err, init_done;
    logic [7:0]  rx_byte;
`ifdef UART_APB_HOST_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    logic [31:0] status_reg;
    logic [31:0] rx_data_reg;
    logic        pready_en;

    xfer_t       exp_q[$];
    logic [7:0]  rx_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_status = 0;
    int n_tx_ready = 0;
    int n_rx_valid = 0;
    int n_rx_err = 0;
    int n_bus_err = 0;
    int acc_run = 0;
    int last_run = 0;
    longint t_status = 0;

    always #5 PCLK = ~PCLK;

    assign PREADY = pready_en;
    assign PRDATA = (PADDR[3:0] == 4'h4) ? status_reg :
                    (PADDR[3:0] == 4'hC) ? rx_data_reg : 32'h0;

    uart_apb_host #(
        .ADDR_BASE (32'h0000_0000),
        .POLL_GAP  (4),
        .TIMEOUT   (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_err    (rx_err),
        .bus_err   (bus_err),
        .init_done (init_done)
`ifdef UART_APB_HOST_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: scoreboard for APB transfers and RX bytes, plus slave side effects.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            acc_run++;
        end else if (!PSEL) begin
            if (acc_run != 0) last_run = acc_run;
            acc_run = 0;
        end
        if (!PRESET && PSEL && PENABLE && PREADY) begin
            if (!PWRITE && PADDR == 32'h4) begin
                n_status++;
                t_status = $time;
            end else if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_xfer: got addr %0h wr %0b data %0h, required none",
                         PADDR, PWRITE, PWDATA);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                check("apb_xfer", {7'd0, PADDR, PWRITE, (PWRITE ? PWDATA : 32'h0)},
                      {7'd0, e.addr, e.wr, e.data});
            end
            if (!PWRITE && PADDR == 32'hC) status_reg[3] = 1'b0;
            if (PWRITE && PADDR == 32'h0 && PWDATA[3]) status_reg = 32'h0;
        end
        if (!PRESET && rx_valid) begin
            n_rx_valid++;
            if (rx_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rx: got %0h, required none", rx_byte);
            end else begin
                check("rx_byte", {64'd0, rx_byte}, {64'd0, rx_q.pop_front()});
            end
        end
        if (!PRESET && tx_ready) n_tx_ready++;
        if (!PRESET && rx_err) n_rx_err++;
        if (!PRESET && bus_err) begin
            n_bus_err++;
            check("timeout_len", 72'(last_run), 72'd16);
        end
    end

    task automatic wait_status(output longint t, output logic ok);
        int n0;
        n0 = n_status;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (n_status != n0) begin
                ok = 1'b1;
                t  = t_status;
                break;
            end
        end
    endtask

    task automatic wait_tx_ready(output int lat, output logic ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge PCLK);
            if (tx_ready) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        longint t1, t2;
        logic   ok1, ok2;
        int     lat, n0;

        PRESET      = 1'b1;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;
        pready_en   = 1'b1;
        status_reg  = 32'h0;
        rx_data_reg = 32'h0;

        repeat (3) @(negedge PCLK);
        check("reset_outputs",
              {39'd0, PSEL, PENABLE, PWRITE, tx_ready, rx_valid, rx_err, bus_err, init_done, rx_byte, PADDR[15:0]},
              72'd0);

        exp_q.push_back('{32'h0, 1'b1, 32'h0A});
        exp_q.push_back('{32'h0, 1'b1, 32'h05});
        PRESET = 1'b0;
        ok1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (init_done) begin ok1 = 1'b1; break; end
        end
        check("init_done", {71'd0, ok1}, 72'd1);

        wait_status(t1, ok1);
        wait_status(t2, ok2);
        check("poll_wait", {70'd0, ok1, ok2}, 72'd3);
        check("poll_period", 72'((t2 - t1) / 10), 72'd7);

        exp_q.push_back('{32'h8, 1'b1, 32'h5A});
        tx_byte  = 8'h5A;
        tx_valid = 1'b1;
        wait_tx_ready(lat, ok1);
        tx_valid = 1'b0;
        check("tx_seen", {71'd0, ok1}, 72'd1);
        check("tx_latency_le_10", {71'd0, (lat <= 10)}, 72'd1);
        repeat (20) @(negedge PCLK);
        check("tx_ready_count", 72'(n_tx_ready), 72'd1);

        status_reg = 32'h1;
        tx_byte    = 8'h33;
        tx_valid   = 1'b1;
        repeat (30) @(negedge PCLK);
        check("busy_no_tx", 72'(n_tx_ready), 72'd1);
        exp_q.push_back('{32'h8, 1'b1, 32'h33});
        status_reg = 32'h0;
        wait_tx_ready(lat, ok1);
        tx_valid = 1'b0;
        check("tx_after_busy", {71'd0, ok1}, 72'd1);
        repeat (20) @(negedge PCLK);
        check("tx_ready_count2", 72'(n_tx_ready), 72'd2);

        rx_data_reg = 32'hC3;
        exp_q.push_back('{32'hC, 1'b0, 32'h0});
        rx_q.push_back(8'hC3);
        status_reg = 32'h8;
        ok1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (n_rx_valid == 1) begin ok1 = 1'b1; break; end
        end
        check("rx_seen", {71'd0, ok1}, 72'd1);
        repeat (5) @(negedge PCLK);
        check("rx_byte_held", {63'd0, rx_valid, rx_byte}, {63'd0, 1'b0, 8'hC3});

        exp_q.push_back('{32'h0, 1'b1, 32'h09});
        exp_q.push_back('{32'h0, 1'b1, 32'h05});
        status_reg = 32'h18;
        repeat (40) @(negedge PCLK);
        check("err_xfers_done", 72'(exp_q.size()), 72'd0);
        check("rx_err_count", 72'(n_rx_err), 72'd1);
        check("rx_valid_count", 72'(n_rx_valid), 72'd1);

        pready_en = 1'b0;
        ok1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (n_bus_err == 1) begin ok1 = 1'b1; break; end
        end
        pready_en = 1'b1;
        check("bus_err_seen", {71'd0, ok1}, 72'd1);
        n0 = n_status;
        repeat (20) @(negedge PCLK);
        check("bus_err_count", 72'(n_bus_err), 72'd1);
        check("poll_resumed", {71'd0, (n_status > n0)}, 72'd1);
`ifdef UART_APB_HOST_ERRCNT_EN
        check("err_count", {64'd0, err_count}, 72'd2);
`endif
        check("queues_empty", 72'(exp_q.size() + rx_q.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
